// File: rtl/uart_tx_framer.sv
// 8N1 UART transmitter with a one-entry holding buffer for gap-free back-to-back frames.
// Line, busy and done are registered from the state, so they trail the FSM by one clock.
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data_in,
    output logic       tx_ready,
    output logic       tx_data_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    logic w_baud_last;
    logic w_stop_end;
    logic w_accept;
    logic w_direct;
    logic w_to_hold;
    logic w_line;

    // Handshake and bit-boundary decode
    always_comb begin
        w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));
        w_stop_end  = (r_state == S_STOP) && w_baud_last && (r_bit == 3'(STOP_BITS - 1));
        w_accept    = tx_valid && !r_hold_full;
        // A byte offered on the final stop clock with an empty hold goes straight to the shifter
        w_direct    = w_accept && ((r_state == S_IDLE) || w_stop_end);
        w_to_hold   = w_accept && !w_direct;
        case (r_state)
            S_IDLE:  w_line = 1'b1;
            S_START: w_line = 1'b0;
            S_DATA:  w_line = r_shift[0];
            S_STOP:  w_line = 1'b1;
            default: w_line = 1'b1;
        endcase
    end

    // Registered serial outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_busy <= (r_state != S_IDLE);
            r_done <= w_stop_end;
        end
    end

    // Holding buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else if (w_stop_end && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_to_hold) begin
            r_hold      <= tx_data_in;
            r_hold_full <= 1'b1;
        end else begin
            r_hold_full <= r_hold_full;
        end
    end

    // Baud counter: free-runs while framing, wraps on every bit boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud <= '0;
        end else if ((r_state == S_IDLE) || w_baud_last) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + BW'(1);
        end
    end

    // Frame sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bit <= 3'd0;
                    if (w_direct) begin
                        r_shift <= tx_data_in;
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_state <= S_START;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_bit   <= 3'd0;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_bit <= 3'd0;
                        if (r_hold_full) begin
                            r_shift <= r_hold;
                            r_state <= S_START;
                        end else if (w_direct) begin
                            r_shift <= tx_data_in;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_baud_last) begin
                        r_bit <= r_bit + 3'd1;
                    end else begin
                        r_state <= S_STOP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_bit   <= 3'd0;
                end
            endcase
        end
    end

    assign tx_ready    = !r_hold_full;
    assign tx_data_out = r_tx;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized bench for uart_tx_framer: a frame-schedule reference model predicts every
// clock of the line/ready/busy/done outputs, and a sampling receiver checks byte order.
module tb_uart_tx_framer;

    localparam int CPB = 3;
    localparam int SB  = 1;
    localparam int FL  = (9 + SB) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data_in;
    logic       tx_ready;
    logic       tx_data_out;
    logic       tx_busy;
    logic       tx_done;

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data_in(tx_data_in),
        .tx_ready(tx_ready), .tx_data_out(tx_data_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    // One scheduled frame: byte, edge it was accepted on, first line period of its start bit
    typedef struct {
        logic [7:0] b;
        int         acc;
        int         s;
    } frame_t;

    frame_t     fq[$];
    logic [7:0] rxq[$];
    int         t_free = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic       m_acc;
    logic       rx_act = 1'b0;
    int         rx_off;
    logic [7:0] rx_sh;
    int         done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Hold is occupied from the accepting edge until the edge before its frame starts
    function automatic logic m_ready();
        foreach (fq[i]) if (fq[i].acc <= cyc && cyc < fq[i].s - 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_line();
        int k;
        foreach (fq[i]) begin
            if (cyc >= fq[i].s && cyc < fq[i].s + FL) begin
                k = (cyc - fq[i].s) / CPB;
                if (k == 0) return 1'b0;
                else if (k <= 8) return fq[i].b[k-1];
                else return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        foreach (fq[i]) if (cyc >= fq[i].s && cyc < fq[i].s + FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_done();
        foreach (fq[i]) if (cyc == fq[i].s + FL - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        int s;
        m_acc = tx_valid && m_ready() && !rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            fq.delete();
            rxq.delete();
            t_free = 0;
        end else if (m_acc) begin
            s = (cyc + 1 > t_free) ? cyc + 1 : t_free;
            fq.push_back('{b: tx_data_in, acc: cyc, s: s});
            rxq.push_back(tx_data_in);
            t_free = s + FL;
        end
        while (fq.size() > 0 && cyc >= fq[0].s + FL) void'(fq.pop_front());
        @(negedge clk);
        chk("line",  32'(tx_data_out), 32'(m_line()));
        chk("ready", 32'(tx_ready),    32'(m_ready()));
        chk("busy",  32'(tx_busy),     32'(m_busy()));
        chk("done",  32'(tx_done),     32'(m_done()));
        if (tx_done) done_cnt++;
        // Mid-bit sampling receiver
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx_data_out == 1'b0) begin
                rx_act = 1'b1;
                rx_off = 0;
            end
        end else begin
            rx_off++;
            if (rx_off >= 4 && rx_off <= 25 && (rx_off % CPB) == 1) rx_sh[(rx_off - 4) / CPB] = tx_data_out;
            if (rx_off == 9 * CPB + 1) begin
                chk("rx_stop", 32'(tx_data_out), 32'd1);
                chk("rx_pending", 32'(rxq.size() > 0), 32'd1);
                if (rxq.size() > 0) chk("rx_byte", 32'(rx_sh), 32'(rxq.pop_front()));
                rx_act = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [7:0] b);
        tx_valid   = 1'b1;
        tx_data_in = b;
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_acc) break;
        end
        chk("send_accepted", 32'(m_acc), 32'd1);
        tx_valid   = 1'b0;
        tx_data_in = 8'($urandom);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data_in = 8'h00;
        idle(20);
        rst = 1'b0;
        idle(3);

        // Single frame from idle, then two back-to-back frames
        d0 = done_cnt;
        send(8'hA5);
        idle(35);
        chk("a5_done_pulses", 32'(done_cnt - d0), 32'd1);
        d0 = done_cnt;
        send(8'h00);
        send(8'hFF);
        idle(65);
        chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

        // Third byte offered while shifter and hold are both occupied
        send(8'h11);
        send(8'h22);
        send(8'h33);
        idle(95);

        // Reset during data bit 4 of 0x3C, then a clean frame
        send(8'h3C);
        idle(16);
        rst = 1'b1;
        step();
        rst = 1'b0;
        d0 = done_cnt;
        send(8'h81);
        idle(35);
        chk("post_rst_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Every byte value back-to-back
        for (int b = 0; b < 256; b++) send(8'(b));
        idle(70);
        chk("rx_drained", 32'(rxq.size()), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tx_valid   = ($urandom_range(0, 3) == 0);
            tx_data_in = 8'($urandom);
            rst        = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        idle(100);
        chk("final_rx_drained", 32'(rxq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
